// File: rtl/fli_pipe.sv
// fli_pipe: two-stage fli.{h,s,d,q} immediate generator behind a valid/ready handshake.
// Stage 1 decodes the shared value table, stage 2 rebiases into the format and NaN-boxes.
module fli_pipe #(
    parameter int FLEN          = 64,
    parameter int FMTBITS       = 2,
    parameter bit ZFH_SUPPORTED = 1,
    parameter bit D_SUPPORTED   = 1,
    parameter bit Q_SUPPORTED   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Flush,
    input  logic               ValidIn,
    output logic               ReadyOut,
    input  logic [4:0]         Rs1,
    input  logic [FMTBITS-1:0] Fmt,
    output logic               ValidOut,
    input  logic               ReadyIn,
    output logic [FLEN-1:0]    Imm,
    output logic               Illegal
);
    localparam logic [1:0] NORM = 2'd0, MINNORM = 2'd1, INF = 2'd2, QNAN = 2'd3;

    logic                     v1_q, v2_q, s1_acc, s2_acc;
    logic                     sgn_d, sgn_q, ill_d, ill_q, s2_ill_q;
    logic [1:0]               cls_d, cls_q, f_d, f_q;
    logic signed [5:0]        e_d, e_q;
    logic [FMTBITS-1:0]       fmt_q;
    logic [FLEN-1:0]          imm_d, imm_q;

    // Encodes one table entry into a (1, ne, nf) format; overflow saturates to +inf.
    function automatic logic [127:0] enc(input int ne, input int nf, input logic sg,
                                         input logic [1:0] cl, input logic signed [5:0] e,
                                         input logic [1:0] f);
        logic [127:0] em, ex, fr;
        logic s;
        int be;
        em = (128'd1 << ne) - 128'd1;
        be = int'(e) + (1 << (ne - 1)) - 1;
        s  = 1'b0;
        ex = em;
        fr = '0;
        if (cl == QNAN) fr = 128'd1 << (nf - 1);
        else if (cl == MINNORM) ex = 128'd1;
        else if (cl == NORM && be < (1 << ne) - 1) begin
            s  = sg;
            ex = be > 0 ? 128'(be) : '0;
            fr = be > 0 ? 128'(f) << (nf - 2) : 128'({1'b1, f}) << (nf - 2) >> (1 - be);
        end
        return (128'(s) << (ne + nf)) | (ex << nf) | fr;
    endfunction

    function automatic logic [FLEN-1:0] box(input logic [127:0] v, input int w);
        return ({FLEN{1'b1}} << w) | FLEN'(v);
    endfunction

    assign s2_acc   = !v2_q || ReadyIn;
    assign s1_acc   = !v1_q || s2_acc;
    assign ReadyOut = s1_acc;
    assign ValidOut = v2_q;
    assign Imm      = imm_q;
    assign Illegal  = s2_ill_q;

    always_comb begin
        sgn_d = Rs1 == 5'd0;
        cls_d = Rs1 == 5'd1 ? MINNORM : Rs1 == 5'd30 ? INF : Rs1 == 5'd31 ? QNAN : NORM;
        f_d   = Rs1 >= 5'd8 && Rs1 <= 5'd22 ? Rs1[1:0] : 2'd0;
        case (Rs1)
            5'd2:                       e_d = -6'sd16;
            5'd3:                       e_d = -6'sd15;
            5'd4:                       e_d = -6'sd8;
            5'd5:                       e_d = -6'sd7;
            5'd6:                       e_d = -6'sd4;
            5'd7:                       e_d = -6'sd3;
            5'd8, 5'd9, 5'd10, 5'd11:   e_d = -6'sd2;
            5'd12, 5'd13, 5'd14, 5'd15: e_d = -6'sd1;
            5'd20, 5'd21, 5'd22:        e_d = 6'sd1;
            5'd23:                      e_d = 6'sd2;
            5'd24:                      e_d = 6'sd3;
            5'd25:                      e_d = 6'sd4;
            5'd26:                      e_d = 6'sd7;
            5'd27:                      e_d = 6'sd8;
            5'd28:                      e_d = 6'sd15;
            5'd29:                      e_d = 6'sd16;
            default:                    e_d = 6'sd0;
        endcase
        ill_d = Fmt == FMTBITS'(0) ? 1'b0 :
                Fmt == FMTBITS'(1) ? !D_SUPPORTED :
                Fmt == FMTBITS'(2) ? !ZFH_SUPPORTED :
                Fmt == FMTBITS'(3) ? !Q_SUPPORTED : 1'b1;
    end

    always_comb begin
        imm_d = ill_q               ? '0 :
                fmt_q == FMTBITS'(0) ? box(enc(8, 23, sgn_q, cls_q, e_q, f_q), 32) :
                fmt_q == FMTBITS'(1) ? box(enc(11, 52, sgn_q, cls_q, e_q, f_q), 64) :
                fmt_q == FMTBITS'(2) ? box(enc(5, 10, sgn_q, cls_q, e_q, f_q), 16) :
                                       box(enc(15, 112, sgn_q, cls_q, e_q, f_q), 128);
    end

    // Flush only clears valid bits; data registers are allowed to keep stale contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            sgn_q    <= 1'b0;
            cls_q    <= NORM;
            e_q      <= 6'sd0;
            f_q      <= 2'd0;
            fmt_q    <= '0;
            ill_q    <= 1'b0;
            imm_q    <= '0;
            s2_ill_q <= 1'b0;
        end else begin
            v1_q <= !Flush && (s1_acc ? ValidIn : v1_q);
            v2_q <= !Flush && (s2_acc ? v1_q : v2_q);
            if (s1_acc && ValidIn) begin
                sgn_q <= sgn_d;
                cls_q <= cls_d;
                e_q   <= e_d;
                f_q   <= f_d;
                fmt_q <= Fmt;
                ill_q <= ill_d;
            end
            if (s2_acc && v1_q) begin
                imm_q    <= imm_d;
                s2_ill_q <= ill_q;
            end
        end
    end
endmodule
